// File: rtl/ahb_wburst_master.sv
// AHB-Lite INCR write-burst master: pops 64-bit beats from the bridge write FIFO
// and issues them as a burst with wait-state, BUSY and ERROR handling.
module ahb_wburst_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic              hresp,
  output logic              done_valid,
  output logic              done_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_BUSY  = 3'd3;
  localparam logic [2:0] S_LAST  = 3'd4;
  localparam logic [2:0] S_DRAIN = 3'd5;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  localparam logic [LEN_W:0]  CNT_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

  logic [2:0]        state;
  logic [LEN_W:0]    beats_to_fetch;
  logic [LEN_W:0]    beats_to_issue;
  logic [DATA_W-1:0] hold_data;
  logic              hold_vld;
  logic              sticky_err;
  logic              err_done;
  logic              addr_accept;
  logic              pop;
  logic              err_first;
  logic [ADDR_W-1:0] haddr_next;
  logic              next_cross_1k;

  assign cmd_ready   = (state == S_IDLE);
  assign hburst      = 3'b001;
  assign addr_accept = hready && htrans[1];
  assign err_first   = hresp && !hready;
  assign haddr_next  = haddr + (ADDR_ONE << hsize);
  assign next_cross_1k = (haddr_next[9:0] == 10'd0);

  // While draining after an error the hold register is bypassed, so pops do
  // not wait for it to empty.
  always_comb begin
    pop = 1'b0;
    if (beats_to_fetch != '0 && !fifo_empty) begin
      if (state == S_DRAIN)
        pop = 1'b1;
      else
        pop = !hold_vld || addr_accept;
    end
  end

  assign fifo_rd_en = pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      beats_to_fetch <= '0;
      beats_to_issue <= '0;
      hold_data      <= '0;
      hold_vld       <= 1'b0;
      sticky_err     <= 1'b0;
      err_done       <= 1'b0;
      haddr          <= '0;
      htrans         <= T_IDLE;
      hwrite         <= 1'b0;
      hsize          <= '0;
      hwdata         <= '0;
      done_valid     <= 1'b0;
      done_err       <= 1'b0;
    end else begin
      done_valid <= 1'b0;
      done_err   <= 1'b0;

      if (pop)
        beats_to_fetch <= beats_to_fetch - CNT_ONE;

      if (addr_accept) begin
        hwdata   <= hold_data;
        hold_vld <= 1'b0;
      end
      if (pop && state != S_DRAIN) begin
        hold_data <= fifo_data;
        hold_vld  <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            haddr          <= cmd_addr;
            hsize          <= cmd_size;
            beats_to_fetch <= {1'b0, cmd_len} + CNT_ONE;
            beats_to_issue <= {1'b0, cmd_len} + CNT_ONE;
            sticky_err     <= 1'b0;
            err_done       <= 1'b0;
            hold_vld       <= 1'b0;
            state          <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (hold_vld || pop) begin
            htrans <= T_NONSEQ;
            hwrite <= 1'b1;
            state  <= S_ADDR;
          end
        end

        S_ADDR: begin
          if (err_first) begin
            htrans     <= T_IDLE;
            hwrite     <= 1'b0;
            sticky_err <= 1'b1;
            err_done   <= 1'b0;
            hold_vld   <= 1'b0;
            state      <= S_DRAIN;
          end else if (addr_accept) begin
            haddr          <= haddr_next;
            beats_to_issue <= beats_to_issue - CNT_ONE;
            if (beats_to_issue == CNT_ONE) begin
              htrans <= T_IDLE;
              hwrite <= 1'b0;
              state  <= S_LAST;
            end else if (pop) begin
              htrans <= next_cross_1k ? T_NONSEQ : T_SEQ;
            end else begin
              htrans <= T_BUSY;
              state  <= S_BUSY;
            end
          end
        end

        S_BUSY: begin
          if (err_first) begin
            htrans     <= T_IDLE;
            hwrite     <= 1'b0;
            sticky_err <= 1'b1;
            err_done   <= 1'b0;
            hold_vld   <= 1'b0;
            state      <= S_DRAIN;
          end else if (hold_vld || pop) begin
            htrans <= (haddr[9:0] == 10'd0) ? T_NONSEQ : T_SEQ;
            state  <= S_ADDR;
          end
        end

        S_LAST: begin
          if (err_first) begin
            sticky_err <= 1'b1;
            err_done   <= 1'b0;
            state      <= S_DRAIN;
          end else if (hready) begin
            done_valid <= 1'b1;
            done_err   <= sticky_err;
            state      <= S_IDLE;
          end
        end

        S_DRAIN: begin
          // hready here marks the second cycle of the two-cycle ERROR response.
          if (hready)
            err_done <= 1'b1;
          if (beats_to_fetch == '0 && (err_done || hready)) begin
            done_valid <= 1'b1;
            done_err   <= 1'b1;
            state      <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
